// File: rtl/traffic_lights_pkg.sv
// Shared encodings for the traffic_lights intersection controller.
package traffic_lights_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } light_state_t;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_PARADE = 1'b1
  } mode_state_t;

endpackage

// File: rtl/traffic_lights_parade_mode.sv
// Parade mode latch: p enters parade, r leaves it; m is high while in parade.
module parade_mode
  import traffic_lights_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic p,
  input  logic r,
  output logic m
);

  mode_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= MODE_NORMAL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    m          = 1'b0;
    case (state)
      MODE_NORMAL: if (p) state_next = MODE_PARADE;
      MODE_PARADE: begin
        m = 1'b1;
        if (r) state_next = MODE_NORMAL;
      end
      default: state_next = MODE_NORMAL;
    endcase
  end

endmodule

// File: rtl/traffic_lights.sv
// Two-road traffic-light Moore FSM with yellow-phase counter.
// Parade mode (Bravado held green) is built only when TRAFFIC_PARADE_EN is defined.
module traffic_lights
  import traffic_lights_pkg::*;
#(
  parameter int YELLOW_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p,
  input  logic       r,
  input  logic       ta,
  input  logic       tb,
  output logic [2:0] la,
  output logic [2:0] lb
);

  localparam int CW = (YELLOW_CYCLES > 1) ? $clog2(YELLOW_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(YELLOW_CYCLES - 1);

  light_state_t  state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          m;

`ifdef TRAFFIC_PARADE_EN
  parade_mode u_parade_mode (
    .clk   (clk),
    .reset (reset),
    .p     (p),
    .r     (r),
    .m     (m)
  );
`else
  logic unused_parade_inputs;
  assign unused_parade_inputs = p ^ r;
  assign m = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Counter stays 0 outside yellow phases, so each yellow phase starts from 0.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    la         = LIGHT_RED;
    lb         = LIGHT_RED;
    case (state)
      S0: begin
        la = LIGHT_GREEN;
        if (!ta) state_next = S1;
      end
      S1: begin
        la = LIGHT_YELLOW;
        if (cnt == LAST) state_next = S2;
        else             cnt_next   = cnt + CW'(1);
      end
      S2: begin
        lb = LIGHT_GREEN;
        if (!m && !tb) state_next = S3;
      end
      S3: begin
        lb = LIGHT_YELLOW;
        if (cnt == LAST) state_next = S0;
        else             cnt_next   = cnt + CW'(1);
      end
      default: state_next = S0;
    endcase
  end

endmodule

// File: tb/tb_traffic_lights.sv
// Bench for traffic_lights: two instances (yellow = 1 and 3 cycles) share stimulus
// and are checked every cycle against a spec model via an expected queue.
module tb_traffic_lights;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk = 1'b0;
  logic       reset, p, r, ta, tb;
  logic [2:0] la1, lb1, la3, lb3;

  int n_pass  = 0;
  int n_total = 0;

  logic [12:0] exp_q[$];

  int   ms[2];
  int   yl[2];
  int   yc[2] = '{1, 3};
  logic mm;

  always #5 clk = ~clk;

  traffic_lights #(.YELLOW_CYCLES(1)) u_y1 (
    .clk(clk), .reset(reset), .p(p), .r(r), .ta(ta), .tb(tb), .la(la1), .lb(lb1)
  );

  traffic_lights #(.YELLOW_CYCLES(3)) u_y3 (
    .clk(clk), .reset(reset), .p(p), .r(r), .ta(ta), .tb(tb), .la(la3), .lb(lb3)
  );

  function automatic logic [2:0] la_of(int s);
    return (s == 0) ? G : (s == 1) ? Y : R;
  endfunction

  function automatic logic [2:0] lb_of(int s);
    return (s == 2) ? G : (s == 3) ? Y : R;
  endfunction

  // Light model uses the mode value from before this edge; mode updates afterwards.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ms[i] = 0;
        yl[i] = 0;
      end else begin
        case (ms[i])
          0: if (!ta) begin ms[i] = 1; yl[i] = yc[i]; end
          1: begin yl[i] = yl[i] - 1; if (yl[i] == 0) ms[i] = 2; end
          2: if (!mm && !tb) begin ms[i] = 3; yl[i] = yc[i]; end
          default: begin yl[i] = yl[i] - 1; if (yl[i] == 0) ms[i] = 0; end
        endcase
      end
    end
`ifdef TRAFFIC_PARADE_EN
    if (reset)          mm = 1'b0;
    else if (!mm && p)  mm = 1'b1;
    else if (mm && r)   mm = 1'b0;
`else
    mm = 1'b0;
`endif
  endtask

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, got, want);
  endtask

  task automatic check_inv(input string tag, input logic [2:0] a, input logic [2:0] b);
    n_total++;
    assert ($onehot(a) && $onehot(b) && (a == R || b == R)) n_pass++;
    else $error("FAIL %s t=%0t observed la=%b lb=%b expected one-hot with a red", tag, $time, a, b);
  endtask

  task automatic step();
    logic [12:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back({mm, la_of(ms[0]), lb_of(ms[0]), la_of(ms[1]), lb_of(ms[1])});
    #1;
    e = exp_q.pop_front();
    check("m_y1", {2'b00, u_y1.m}, {2'b00, e[12]});
    check("la_y1", la1, e[11:9]);
    check("lb_y1", lb1, e[8:6]);
    check("la_y3", la3, e[5:3]);
    check("lb_y3", lb3, e[2:0]);
    check_inv("inv_y1", la1, lb1);
    check_inv("inv_y3", la3, lb3);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; p = 1'b0; r = 1'b0; ta = 1'b1; tb = 1'b0;
    ms = '{0, 0}; yl = '{0, 0}; mm = 1'b0;
    steps(2);
    reset = 1'b0;
    steps(10);

    // Full cycle with no traffic anywhere.
    ta = 1'b0; tb = 1'b0;
    steps(10);

    // Long yellow then Bravado held green by traffic.
    reset = 1'b1; ta = 1'b1; step();
    reset = 1'b0; ta = 1'b0; tb = 1'b1;
    steps(10);
    tb = 1'b0;
    steps(6);

    // Parade requested during Academic green, held through S2, then released.
    reset = 1'b1; ta = 1'b1; tb = 1'b0; step();
    reset = 1'b0; p = 1'b1; step();
    p = 1'b0; ta = 1'b0;
    steps(25);
    r = 1'b1; step();
    r = 1'b0;
    steps(8);

    // Reset in S2 during parade, then a normal pass through S2.
    ta = 1'b1; p = 1'b1; step();
    p = 1'b0; ta = 1'b0;
    steps(8);
    reset = 1'b1; step();
    reset = 1'b0;
    steps(10);

    // p rising while already in S2 with no Bravado traffic.
    ta = 1'b0; tb = 1'b1;
    steps(6);
    tb = 1'b0; p = 1'b1; step();
    p = 1'b0;
    steps(6);
    r = 1'b1; step();
    r = 1'b0;

    // Simultaneous p and r toggle the mode every edge.
    p = 1'b1; r = 1'b1;
    steps(6);
    p = 1'b0; r = 1'b0;
    steps(6);

    // Randomised traffic, parade and occasional reset.
    for (int i = 0; i < 400; i++) begin
      ta    = 1'($urandom_range(0, 1));
      tb    = 1'($urandom_range(0, 1));
      p     = ($urandom_range(0, 15) == 0);
      r     = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
